dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Load/store unit sitting between the core's execute stage and the data memory. It accepts one RV32I load or store request at a time and issues a single access to the data memory, which uses a registered read port. It generates byte write enables and lane-replicated store data, then captures read data one cycle after issue and extracts and sign- or zero-extends the addressed byte, halfword or word. It returns a single-cycle response with an error flag for illegal or misaligned accesses.

## Interface
- `MMIO_BIT`, 20: address bit that selects the special/IO region of data memory.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: core request present.
- `req_ready` out 1: LSU can accept a request. High only in IDLE.
- `req_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: unshifted store data (rs2).
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data. 0 for stores and errors.
- `resp_err` out 1: request rejected. Qualified by `resp_valid`.
- `mem_rd` out 1: read strobe to data memory.
- `mem_we` out 4: byte write enables to data memory.
- `mem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rdata` in 32: data memory read data. Valid the cycle after `mem_rd` is sampled.

## Operation
- States:
  - IDLE → ISSUE or RESP.
  - ISSUE → CAPTURE (load) or RESP (store).
  - CAPTURE → RESP.
  - RESP → IDLE.
- IDLE, on `req_valid`:
  - Latch the request.
  - Check legality; if illegal, go to RESP with err=1.
  - Otherwise go to ISSUE.
- Illegal requests:
  - Store funct3 not in {000,001,010}.
  - Load funct3 not in {000,001,010,100,101}.
  - Store of sub-word size with `req_addr[MMIO_BIT]`=1. The IO region only supports word writes.
  - Misaligned access, per Configuration.
- ISSUE:
  - `mem_addr` is driven.
  - Load: `mem_rd`=1, `mem_we`=0.
  - Store SB: `mem_we`=0001<<addr[1:0], `mem_wdata`={4{wdata[7:0]}}.
  - Store SH: `mem_we`=0011<<{addr[1],0}, `mem_wdata`={2{wdata[15:0]}}.
  - Store SW: `mem_we`=1111, `mem_wdata`=wdata.
- CAPTURE: at the end of the cycle, register the formatted `mem_rdata` into `resp_rdata`.
  - B/BU: byte at lane addr[1:0], sign bit 7 or zero.
  - H/HU: halfword at addr[1], sign bit 15 or zero.
  - W: unchanged.
- RESP: `resp_valid`=1 for exactly one cycle. `resp_err` and `resp_rdata` are held stable through this cycle.
- Outside ISSUE, `mem_rd`=0 and `mem_we`=0. `mem_addr` and `mem_wdata` hold their last value.
- Requests arriving while `req_ready`=0 are not latched. The core must hold `req_valid` until accepted.

## Timing
- Acceptance edge E0: the edge with `req_valid` & `req_ready`.
- Store: ISSUE in cycle E0–E1; memory writes at E1; `resp_valid` in cycle E1–E2.
- Load: ISSUE E0–E1; memory read registered at E1; CAPTURE E1–E2; `resp_valid` in cycle E2–E3.
- Error: `resp_valid` in cycle E0–E1. No memory strobe is issued.
- Throughput: after RESP, IDLE lasts at least one cycle. Back-to-back store spacing is 3 cycles; load spacing is 4.
- Reset values:
  - State IDLE, so `req_ready`=1.
  - `resp_valid`=0, `resp_err`=0.
  - `resp_rdata`=0, `mem_rd`=0, `mem_we`=0.
  - `mem_addr`=0, `mem_wdata`=0.
- Reset asserted in any state:
  - The transaction is aborted immediately (asynchronous).
  - `mem_we` and `mem_rd` drop in the same instant.
  - No response is produced.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - H/HU with addr[0]=1 → `resp_err`=1.
  - W with addr[1:0]≠0 → `resp_err`=1.
- `LSU_MISALIGN_CHECK_EN` undefined:
  - Offending low address bits are forced to zero: H uses addr[1], W uses lane 0.
  - The access proceeds normally. `resp_err` is raised only for illegal funct3 or MMIO sub-word stores.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → store: ISSUE `mem_we`=1111, `resp_valid` one cycle after E0. Load: `resp_rdata`=0xDEADBEEF two cycles after E0.
- SB wdata 0x123456A5 @0x13 → `mem_we`=1000, `mem_wdata`=0xA5A5A5A5. Then LB @0x13 → 0xFFFFFFA5; LBU @0x13 → 0x000000A5.
- Memory word 0x80011234 at 0x10 → LH @0x12 gives 0xFFFF8001; LHU @0x12 gives 0x00008001; LH @0x10 gives 0x00001234.
- LW @0x06:
  - With macro: `resp_err`=1 at E0+1, `mem_rd` never asserted.
  - Without macro: `mem_addr`=0x04, normal load.
- SB @0x00100010 → `resp_err`=1, `mem_we` stays 0. LW @0x00100000 with `mem_rdata`=0x00D3B63F → `resp_rdata`=0x00D3B63F.
- `rst` low during CAPTURE → no `resp_valid`, all outputs at reset values, `req_ready`=1. After release, an SW completes normally.

Source files
------------

// File: rtl/dmem_lsu.sv
// RV32I load/store unit: one request at a time to a data memory with a registered read port.
// Latency: error 1 cycle, store 2 cycles, load 3 cycles from acceptance to resp_valid.
// Backpressure: req_ready only in IDLE; the core holds req_valid until accepted.
// Optional feature: define LSU_MISALIGN_CHECK_EN to reject misaligned H/W accesses.
module dmem_lsu #(
    parameter int MMIO_BIT = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_rd,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t      state;
    logic        store_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic        f3_ok;
    logic        mmio_bad;
    logic        misalign;
    logic        req_err;
    logic [3:0]  we_nxt;
    logic [31:0] wdata_nxt;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_fmt;

    assign req_ready = (state == IDLE);

    // Request legality: funct3 per direction, IO region word-only stores, optional alignment.
    always_comb begin
        f3_ok = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = !req_store;
            default:                f3_ok = 1'b0;
        endcase
        mmio_bad = req_store && (req_funct3 != 3'b010) && req_addr[MMIO_BIT];
`ifdef LSU_MISALIGN_CHECK_EN
        misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        req_err = !f3_ok || mmio_bad || misalign;
    end

    // Store lane enables and replicated data; offending low bits are simply ignored.
    always_comb begin
        we_nxt    = 4'b0000;
        wdata_nxt = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                we_nxt    = 4'b0001 << req_addr[1:0];
                wdata_nxt = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                we_nxt    = 4'b0011 << {req_addr[1], 1'b0};
                wdata_nxt = {2{req_wdata[15:0]}};
            end
            default: begin
                we_nxt    = 4'b1111;
                wdata_nxt = req_wdata;
            end
        endcase
    end

    // Load data extraction: pick lane by latched offset, extend by funct3[2].
    always_comb begin
        ld_byte  = mem_rdata[{off_q, 3'b000} +: 8];
        ld_half  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_fmt = mem_rdata;
        case (f3_q[1:0])
            2'b00:   load_fmt = f3_q[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   load_fmt = f3_q[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: load_fmt = mem_rdata;
        endcase
    end

    // Transaction FSM with registered memory strobes and response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            store_q    <= 1'b0;
            f3_q       <= 3'b000;
            off_q      <= 2'b00;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            mem_rd     <= 1'b0;
            mem_we     <= 4'b0000;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        store_q    <= req_store;
                        f3_q       <= req_funct3;
                        off_q      <= req_addr[1:0];
                        resp_err   <= req_err;
                        resp_rdata <= 32'h0;
                        if (req_err) begin
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            mem_addr <= {req_addr[31:2], 2'b00};
                            if (req_store) begin
                                mem_we    <= we_nxt;
                                mem_wdata <= wdata_nxt;
                            end else begin
                                mem_rd <= 1'b1;
                            end
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    mem_rd <= 1'b0;
                    mem_we <= 4'b0000;
                    if (store_q) begin
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    resp_rdata <= load_fmt;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                default: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a small registered-read memory stub.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_rd;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int vec = 0;
    int miscmp = 0;

    logic [31:0] mem [16];
    logic [31:0] rdq = 32'h0;

    dmem_lsu #(.MMIO_BIT(20)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory stub: byte-enabled writes, registered read.
    always @(posedge clk) begin
        if (mem_rd) rdq <= mem[mem_addr[5:2]];
        for (int i = 0; i < 4; i++)
            if (mem_we[i]) mem[mem_addr[5:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
    assign mem_rdata = rdq;

    // Observed results of one request.
    int          o_cyc;
    int          o_icyc;
    logic [31:0] o_rdata;
    logic        o_err;
    logic [3:0]  o_we;
    logic [31:0] o_wd;
    logic [31:0] o_ma;
    logic        o_rd;
    logic        o_pulse;

    // Drive one request and record what the DUT does (cycle 1 = cycle after acceptance edge).
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int n;
        o_cyc = -1; o_icyc = -1; o_rdata = 32'h0; o_err = 1'b0;
        o_we = 4'h0; o_wd = 32'h0; o_ma = 32'h0; o_rd = 1'b0; o_pulse = 1'b0;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 10) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_we != 4'h0) begin o_we = mem_we; o_wd = mem_wdata; o_ma = mem_addr; if (o_icyc < 0) o_icyc = c; end
            if (mem_rd) begin o_rd = 1'b1; o_ma = mem_addr; if (o_icyc < 0) o_icyc = c; end
            if (resp_valid) begin o_cyc = c; o_rdata = resp_rdata; o_err = resp_err; break; end
        end
        if (o_cyc > 0) begin @(negedge clk); o_pulse = !resp_valid; end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vec++; if (req_ready !== 1'b1) begin miscmp++; $display("FAIL reset_ready got %b want 1", req_ready); end
        vec++; if (resp_valid !== 1'b0) begin miscmp++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        vec++; if (resp_err !== 1'b0) begin miscmp++; $display("FAIL reset_resp_err got %b want 0", resp_err); end
        vec++; if (resp_rdata !== 32'h0) begin miscmp++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
        vec++; if ({mem_rd, mem_we} !== 5'b0) begin miscmp++; $display("FAIL reset_strobes got %b want 0", {mem_rd, mem_we}); end
        vec++; if ({mem_addr, mem_wdata} !== 64'h0) begin miscmp++; $display("FAIL reset_mem_bus got %h want 0", {mem_addr, mem_wdata}); end
        rst = 1'b1;
    endtask

    task automatic test_word();
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        vec++; if (o_we !== 4'b1111) begin miscmp++; $display("FAIL sw_we got %b want 1111", o_we); end
        vec++; if (o_wd !== 32'hDEADBEEF) begin miscmp++; $display("FAIL sw_wdata got %h want deadbeef", o_wd); end
        vec++; if (o_icyc !== 1) begin miscmp++; $display("FAIL sw_issue_cycle got %0d want 1", o_icyc); end
        vec++; if (o_cyc !== 2) begin miscmp++; $display("FAIL sw_resp_cycle got %0d want 2", o_cyc); end
        vec++; if ({o_err, o_rdata} !== 33'h0) begin miscmp++; $display("FAIL sw_resp got err=%b rdata=%h want 0/0", o_err, o_rdata); end
        vec++; if (o_pulse !== 1'b1) begin miscmp++; $display("FAIL sw_pulse got %b want 1", o_pulse); end
        do_req(1'b0, 3'b010, 32'h10, 32'h0);
        vec++; if (o_rd !== 1'b1 || o_icyc !== 1) begin miscmp++; $display("FAIL lw_rd got rd=%b cyc=%0d want 1/1", o_rd, o_icyc); end
        vec++; if (o_ma !== 32'h10) begin miscmp++; $display("FAIL lw_addr got %h want 10", o_ma); end
        vec++; if (o_cyc !== 3) begin miscmp++; $display("FAIL lw_resp_cycle got %0d want 3", o_cyc); end
        vec++; if (o_rdata !== 32'hDEADBEEF) begin miscmp++; $display("FAIL lw_rdata got %h want deadbeef", o_rdata); end
        vec++; if (o_pulse !== 1'b1) begin miscmp++; $display("FAIL lw_pulse got %b want 1", o_pulse); end
    endtask

    task automatic test_byte();
        do_req(1'b1, 3'b000, 32'h13, 32'h123456A5);
        vec++; if (o_we !== 4'b1000) begin miscmp++; $display("FAIL sb_we got %b want 1000", o_we); end
        vec++; if (o_wd !== 32'hA5A5A5A5) begin miscmp++; $display("FAIL sb_wdata got %h want a5a5a5a5", o_wd); end
        do_req(1'b0, 3'b000, 32'h13, 32'h0);
        vec++; if (o_rdata !== 32'hFFFFFFA5) begin miscmp++; $display("FAIL lb_rdata got %h want ffffffa5", o_rdata); end
        do_req(1'b0, 3'b100, 32'h13, 32'h0);
        vec++; if (o_rdata !== 32'h000000A5) begin miscmp++; $display("FAIL lbu_rdata got %h want 000000a5", o_rdata); end
        do_req(1'b0, 3'b000, 32'h11, 32'h0);
        vec++; if (o_rdata !== 32'hFFFFFFBE) begin miscmp++; $display("FAIL lb1_rdata got %h want ffffffbe", o_rdata); end
    endtask

    task automatic test_half();
        mem[4] = 32'h80011234;
        do_req(1'b0, 3'b001, 32'h12, 32'h0);
        vec++; if (o_rdata !== 32'hFFFF8001) begin miscmp++; $display("FAIL lh_hi got %h want ffff8001", o_rdata); end
        do_req(1'b0, 3'b101, 32'h12, 32'h0);
        vec++; if (o_rdata !== 32'h00008001) begin miscmp++; $display("FAIL lhu_hi got %h want 00008001", o_rdata); end
        do_req(1'b0, 3'b001, 32'h10, 32'h0);
        vec++; if (o_rdata !== 32'h00001234) begin miscmp++; $display("FAIL lh_lo got %h want 00001234", o_rdata); end
        do_req(1'b1, 3'b001, 32'h12, 32'h0000BEEF);
        vec++; if (o_we !== 4'b1100 || o_wd !== 32'hBEEFBEEF) begin miscmp++; $display("FAIL sh got we=%b wd=%h want 1100/beefbeef", o_we, o_wd); end
    endtask

    task automatic test_misalign();
        mem[1] = 32'hCAFEF00D;
        do_req(1'b0, 3'b010, 32'h06, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
        vec++; if (o_err !== 1'b1 || o_cyc !== 1) begin miscmp++; $display("FAIL lw_mis got err=%b cyc=%0d want 1/1", o_err, o_cyc); end
        vec++; if (o_rd !== 1'b0) begin miscmp++; $display("FAIL lw_mis_rd got %b want 0", o_rd); end
`else
        vec++; if (o_ma !== 32'h04 || o_rd !== 1'b1) begin miscmp++; $display("FAIL lw_mis_addr got %h rd=%b want 04/1", o_ma, o_rd); end
        vec++; if (o_err !== 1'b0 || o_rdata !== 32'hCAFEF00D || o_cyc !== 3) begin miscmp++; $display("FAIL lw_mis_data got err=%b %h cyc=%0d want 0/cafef00d/3", o_err, o_rdata, o_cyc); end
`endif
    endtask

    task automatic test_illegal();
        do_req(1'b1, 3'b000, 32'h00100010, 32'h11);
        vec++; if (o_err !== 1'b1 || o_cyc !== 1) begin miscmp++; $display("FAIL sb_mmio got err=%b cyc=%0d want 1/1", o_err, o_cyc); end
        vec++; if (o_we !== 4'h0) begin miscmp++; $display("FAIL sb_mmio_we got %b want 0000", o_we); end
        do_req(1'b0, 3'b011, 32'h10, 32'h0);
        vec++; if (o_err !== 1'b1 || o_rd !== 1'b0 || o_rdata !== 32'h0) begin miscmp++; $display("FAIL ld_f3 got err=%b rd=%b rdata=%h want 1/0/0", o_err, o_rd, o_rdata); end
        do_req(1'b1, 3'b100, 32'h10, 32'h0);
        vec++; if (o_err !== 1'b1 || o_we !== 4'h0) begin miscmp++; $display("FAIL st_f3 got err=%b we=%b want 1/0000", o_err, o_we); end
    endtask

    task automatic test_mmio();
        mem[0] = 32'h00D3B63F;
        do_req(1'b0, 3'b010, 32'h00100000, 32'h0);
        vec++; if (o_err !== 1'b0 || o_rdata !== 32'h00D3B63F) begin miscmp++; $display("FAIL lw_mmio got err=%b %h want 0/00d3b63f", o_err, o_rdata); end
        vec++; if (o_ma !== 32'h00100000) begin miscmp++; $display("FAIL lw_mmio_addr got %h want 00100000", o_ma); end
        do_req(1'b1, 3'b010, 32'h00100008, 32'h55AA55AA);
        vec++; if (o_err !== 1'b0 || o_we !== 4'b1111) begin miscmp++; $display("FAIL sw_mmio got err=%b we=%b want 0/1111", o_err, o_we); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        vec++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin miscmp++; $display("FAIL rstmid_hs got ready=%b valid=%b want 1/0", req_ready, resp_valid); end
        vec++; if ({mem_rd, mem_we, mem_addr, mem_wdata, resp_rdata, resp_err} !== 102'h0) begin miscmp++; $display("FAIL rstmid_outs got rd=%b we=%b a=%h wd=%h rdata=%h err=%b want all 0", mem_rd, mem_we, mem_addr, mem_wdata, resp_rdata, resp_err); end
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
        vec++; if (seen !== 1'b0) begin miscmp++; $display("FAIL rstmid_noresp got %b want 0", seen); end
        do_req(1'b1, 3'b010, 32'h08, 32'h11223344);
        vec++; if (o_cyc !== 2 || o_err !== 1'b0 || o_we !== 4'b1111) begin miscmp++; $display("FAIL rstmid_sw got cyc=%0d err=%b we=%b want 2/0/1111", o_cyc, o_err, o_we); end
    endtask

    // Hold req_valid high and measure the spacing between two acceptances.
    task automatic test_back_to_back(input logic st, input int exp_gap);
        int acc [2];
        int k;
        int gap;
        k = 0;
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h0BADF00D;
        for (int c = 0; c < 20 && k < 2; c++) begin
            if (req_ready) begin acc[k] = c; k++; end
            @(negedge clk);
        end
        req_valid = 1'b0;
        gap = (k == 2) ? acc[1] - acc[0] : -1;
        vec++; if (gap !== exp_gap) begin miscmp++; $display("FAIL b2b_%s_gap got %0d want %0d", st ? "st" : "ld", gap, exp_gap); end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misalign();
        test_illegal();
        test_mmio();
        test_reset_mid();
        test_back_to_back(1'b1, 3);
        test_back_to_back(1'b0, 4);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
